pc_ctrl: RTL and testbench

//  Program-counter controller for the RISC-V fetch stage. It generates the next fetch PC

---
 rtl/pc_ctrl.sv | 124 ++++++++++++
 tb/tb_pc_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Fetch-stage program-counter controller: prioritised redirects, stall,
// target alignment and a circular return-address stack.
module pc_ctrl #(
   parameter int                 XLEN      = 32,
   parameter logic [XLEN-1:0]    RESET_VEC = '0,
   parameter int                 PC_STEP   = 4,
   parameter int                 RAS_DEPTH = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic            i_br_taken,
   input  logic [XLEN-1:0] i_br_target,
   input  logic            i_trap,
   input  logic [XLEN-1:0] i_trap_vec,
   input  logic            i_mret,
   input  logic [XLEN-1:0] i_mepc,
   input  logic            i_call,
   input  logic            i_ret,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_next,
   output logic            o_misalign,
   output logic            o_ras_empty,
   output logic            o_ras_full
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
   localparam logic [XLEN-1:0] LOWM = (PC_STEP == 2) ? XLEN'(1) : XLEN'(3);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            mis_q, mis_d;
   logic [PW-1:0]   tp_q, tp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] ras_q [RAS_DEPTH];

   logic [XLEN-1:0] seq_pc;
   logic            has, full, adv;
   logic            do_pop, do_push;
   logic            wr_en;
   logic [PW-1:0]   wr_idx;

   assign seq_pc  = pc_q + STEP;
   assign has     = (cnt_q != '0);
   assign full    = (cnt_q == CW'(RAS_DEPTH));
   assign adv     = !i_trap && !i_mret && !i_stall;
   assign do_pop  = adv && i_ret && has;
   assign do_push = adv && i_call;

   // One-hot source select; anything unselected falls through to sequential
   always_comb begin
      pc_d  = seq_pc;
      mis_d = 1'b0;
      unique case (1'b1)
         i_trap: begin
            pc_d  = i_trap_vec & ~LOWM;
            mis_d = |(i_trap_vec & LOWM);
         end
         (!i_trap && i_mret): begin
            pc_d  = i_mepc & ~LOWM;
            mis_d = |(i_mepc & LOWM);
         end
         (!i_trap && !i_mret && i_stall): begin
            pc_d = pc_q;
         end
         (adv && i_br_taken): begin
            pc_d  = i_br_target & ~LOWM;
            mis_d = |(i_br_target & LOWM);
         end
         (adv && !i_br_taken && do_pop): begin
            pc_d = ras_q[tp_q];
         end
         default: pc_d = seq_pc;
      endcase
   end

   always_comb begin
      tp_d   = tp_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_idx = tp_q;
      if (i_trap) begin
         cnt_d = '0;
      end else if (do_push && do_pop) begin
         wr_en = 1'b1;
      end else if (do_push) begin
         tp_d   = tp_q + 1'b1;
         wr_idx = tp_q + 1'b1;
         wr_en  = 1'b1;
         cnt_d  = full ? cnt_q : cnt_q + 1'b1;
      end else if (do_pop) begin
         tp_d  = tp_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pc_q  <= RESET_VEC;
         mis_q <= 1'b0;
         tp_q  <= '0;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         mis_q <= mis_d;
         tp_q  <= tp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n && wr_en) begin
         ras_q[wr_idx] <= seq_pc;
      end
   end

   assign o_pc        = pc_q;
   assign o_pc_next   = pc_d;
   assign o_misalign  = mis_q;
   assign o_ras_empty = !has;
   assign o_ras_full  = full;

endmodule

// File: tb/tb_pc_ctrl.sv
// Randomised scoreboard bench for pc_ctrl against a queue-based
// behavioural model of the PC selection and return-address stack.
module tb_pc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, stall, br, trap, mret, call, ret;
   logic [31:0] bt, tv, mepc;
   logic [31:0] pc, pc_next;
   logic        mis, r_empty, r_full;

   always #5 clk = ~clk;

   pc_ctrl dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_stall     (stall),
      .i_br_taken  (br),
      .i_br_target (bt),
      .i_trap      (trap),
      .i_trap_vec  (tv),
      .i_mret      (mret),
      .i_mepc      (mepc),
      .i_call      (call),
      .i_ret       (ret),
      .o_pc        (pc),
      .o_pc_next   (pc_next),
      .o_misalign  (mis),
      .o_ras_empty (r_empty),
      .o_ras_full  (r_full)
   );

   typedef struct {
      logic [31:0] pc;
      logic        mis;
      logic        empty;
      logic        full;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] ras [$];
   logic [31:0] m_pc;
   bit          m_valid = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   // Monitor: the DUT presents a new state after every rising edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         if (pc !== e.pc || mis !== e.mis ||
             r_empty !== e.empty || r_full !== e.full) begin
            n_bad++;
            $display("FAIL state: pc=%h mis=%b emp=%b full=%b, want pc=%h mis=%b emp=%b full=%b",
                     pc, mis, r_empty, r_full, e.pc, e.mis, e.empty, e.full);
         end
      end
   end

   task automatic step(input bit r, input bit st, input bit b,
                       input logic [31:0] btg, input bit tr,
                       input logic [31:0] tvec, input bit mr,
                       input logic [31:0] me, input bit c, input bit rt);
      exp_t        e;
      logic [31:0] npc, pred;
      bit          nm, have;
      @(negedge clk);
      rst_n = r; stall = st; br = b; bt = btg; trap = tr;
      tv = tvec; mret = mr; mepc = me; call = c; ret = rt;
      #1;
      nm = 0;
      if (!r) begin
         npc = 32'h0;
         ras.delete();
      end else if (tr) begin
         npc = {tvec[31:2], 2'b00};
         nm  = (tvec[1:0] != 0);
         ras.delete();
      end else if (mr) begin
         npc = {me[31:2], 2'b00};
         nm  = (me[1:0] != 0);
      end else if (st) begin
         npc = m_pc;
      end else begin
         have = 0;
         pred = 32'h0;
         if (rt && ras.size() > 0) begin
            pred = ras.pop_back();
            have = 1;
         end
         if (c) begin
            ras.push_back(m_pc + 32'd4);
            if (ras.size() > 4) void'(ras.pop_front());
         end
         if (b) begin
            npc = {btg[31:2], 2'b00};
            nm  = (btg[1:0] != 0);
         end else if (have) begin
            npc = pred;
         end else begin
            npc = m_pc + 32'd4;
         end
      end
      if (r && m_valid) begin
         n_cmp++;
         if (pc_next !== npc) begin
            n_bad++;
            $display("FAIL pc_next: got %h want %h", pc_next, npc);
         end
      end
      m_pc    = npc;
      m_valid = 1;
      e.pc    = npc;
      e.mis   = nm;
      e.empty = (ras.size() == 0);
      e.full  = (ras.size() == 4);
      exp_q.push_back(e);
   endtask

   task automatic seq(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic brn(input logic [31:0] t);
      step(1, 0, 1, t, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 0; stall = 0; br = 0; trap = 0; mret = 0;
      call = 0; ret = 0; bt = 0; tv = 0; mepc = 0;
      // reset, then sequential fetch
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h300, 0, 0, 0, 0);
      seq(3);
      brn(32'h40);
      seq(1);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h80, 0, 0, 0, 0, 1, 1);
      step(1, 1, 0, 0, 1, 32'h100, 0, 0, 0, 0);
      // call at 0x10, return from 0x200
      brn(32'h10);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      brn(32'h200);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      // overflow the stack, then unwind past empty
      step(1, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      brn(32'h200);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      // call+ret together, branch beating ret, mret
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(1, 0, 1, 32'h500, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 1, 32'h1236, 0, 0);
      // misaligned target and wraparound
      brn(32'h42);
      seq(1);
      step(1, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
      seq(2);
      // mid-run reset overrides a trap
      step(0, 0, 0, 0, 1, 32'h700, 0, 0, 0, 0);
      seq(2);
      for (int i = 0; i < 3000; i++) begin
         bit          r, st, b, tr, mr, c, rt;
         logic [31:0] t;
         r  = ($urandom_range(0, 199) != 0);
         st = ($urandom_range(0, 6) == 0);
         b  = ($urandom_range(0, 4) == 0);
         tr = ($urandom_range(0, 39) == 0);
         mr = ($urandom_range(0, 29) == 0);
         c  = ($urandom_range(0, 3) == 0);
         rt = ($urandom_range(0, 3) == 0);
         t  = $urandom;
         if ($urandom_range(0, 2) != 0) t[1:0] = 2'b00;
         step(r, st, b, t, tr, $urandom, mr, $urandom, c, rt);
      end
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
